// File: rtl/silencer_fixed_rate.sv
// Fixed-rate silencer: limits per-burst intensity/phase slew for each transducer channel.
// Channel state lives in a RAM read in stage 0 and written back in stage 1.
module silencer_fixed_rate #(
    parameter int DEPTH = 249
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DIN_VALID,
    input  logic [7:0]  INTENSITY_IN,
    input  logic [7:0]  PHASE_IN,
    input  logic [15:0] UPDATE_RATE_INTENSITY,
    input  logic [15:0] UPDATE_RATE_PHASE,
    output logic [7:0]  INTENSITY_OUT,
    output logic [7:0]  PHASE_OUT,
    output logic        DOUT_VALID
);

    localparam int IW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   rate_i_q, rate_i_d, rate_p_q, rate_p_d;
    logic          accept;
    logic [AW-1:0] addr;

    logic          s1_valid_q;
    logic [AW-1:0] s1_addr_q;
    logic [7:0]    s1_ti_q, s1_tp_q;
    logic [15:0]   s1_rate_i_q, s1_rate_p_q;
    logic          s1_init_q;
    logic [31:0]   rd_q;

    logic [DEPTH-1:0] init_q;
    logic [31:0]      mem [DEPTH];

    logic [15:0] ci_cur, cp_cur, t_i, t_p, diff_i, d_p, mag_p, ci_d, cp_d;

    logic [7:0] out_i_q, out_p_q;
    logic       dout_valid_q;

    // Index saturates at DEPTH so overlong bursts are dropped until DIN_VALID falls.
    assign accept = DIN_VALID && (idx_q < DEPTH_IDX);
    assign addr   = idx_q[AW-1:0];

    always_comb begin
        idx_d    = idx_q;
        rate_i_d = rate_i_q;
        rate_p_d = rate_p_q;
        if (!DIN_VALID) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == '0) begin
                rate_i_d = UPDATE_RATE_INTENSITY;
                rate_p_d = UPDATE_RATE_PHASE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q       <= '0;
            rate_i_q    <= '0;
            rate_p_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_ti_q     <= '0;
            s1_tp_q     <= '0;
            s1_rate_i_q <= '0;
            s1_rate_p_q <= '0;
            s1_init_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            rate_i_q    <= rate_i_d;
            rate_p_q    <= rate_p_d;
            s1_valid_q  <= accept;
            s1_addr_q   <= addr;
            s1_ti_q     <= INTENSITY_IN;
            s1_tp_q     <= PHASE_IN;
            s1_rate_i_q <= rate_i_d;
            s1_rate_p_q <= rate_p_d;
            s1_init_q   <= accept ? init_q[addr] : 1'b0;
        end
    end

    // RAM cannot be cleared by reset; a per-channel written flag makes unwritten entries read as zero.
    always_ff @(posedge CLK) begin
        if (s1_valid_q) begin
            mem[s1_addr_q] <= {ci_d, cp_d};
        end
        if (accept) begin
            rd_q <= mem[addr];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_q <= '0;
        end else if (s1_valid_q) begin
            init_q[s1_addr_q] <= 1'b1;
        end
    end

    always_comb begin
        ci_cur = s1_init_q ? rd_q[31:16] : 16'd0;
        cp_cur = s1_init_q ? rd_q[15:0]  : 16'd0;
        t_i    = {s1_ti_q, 8'h00};
        t_p    = {s1_tp_q, 8'h00};
        diff_i = '0;
        ci_d   = ci_cur;
        if (t_i >= ci_cur) begin
            diff_i = t_i - ci_cur;
            ci_d   = (diff_i <= s1_rate_i_q) ? t_i : ci_cur + s1_rate_i_q;
        end else begin
            diff_i = ci_cur - t_i;
            ci_d   = (diff_i <= s1_rate_i_q) ? t_i : ci_cur - s1_rate_i_q;
        end
        // Phase takes the shortest path; an exact half turn (0x8000) moves forward.
        d_p   = t_p - cp_cur;
        mag_p = d_p[15] ? (16'd0 - d_p) : d_p;
        if (mag_p <= s1_rate_p_q) begin
            cp_d = t_p;
        end else if (d_p[15] && (d_p != 16'h8000)) begin
            cp_d = cp_cur - s1_rate_p_q;
        end else begin
            cp_d = cp_cur + s1_rate_p_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_i_q      <= '0;
            out_p_q      <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_i_q <= ci_d[15:8];
                out_p_q <= cp_d[15:8];
            end
        end
    end

    assign INTENSITY_OUT = out_i_q;
    assign PHASE_OUT     = out_p_q;
    assign DOUT_VALID    = dout_valid_q;

endmodule

// File: tb/tb_silencer_fixed_rate.sv
// Bench for silencer_fixed_rate: per-channel reference model feeds an expected queue
// that is drained as DOUT_VALID cycles appear.
module tb_silencer_fixed_rate;

    localparam int DEPTH = 249;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic [7:0]  INTENSITY_IN = '0;
    logic [7:0]  PHASE_IN = '0;
    logic [15:0] UPDATE_RATE_INTENSITY = '0;
    logic [15:0] UPDATE_RATE_PHASE = '0;
    logic [7:0]  INTENSITY_OUT;
    logic [7:0]  PHASE_OUT;
    logic        DOUT_VALID;

    silencer_fixed_rate #(.DEPTH(DEPTH)) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .DIN_VALID             (DIN_VALID),
        .INTENSITY_IN          (INTENSITY_IN),
        .PHASE_IN              (PHASE_IN),
        .UPDATE_RATE_INTENSITY (UPDATE_RATE_INTENSITY),
        .UPDATE_RATE_PHASE     (UPDATE_RATE_PHASE),
        .INTENSITY_OUT         (INTENSITY_OUT),
        .PHASE_OUT             (PHASE_OUT),
        .DOUT_VALID            (DOUT_VALID)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int ci_m [DEPTH];
    int cp_m [DEPTH];
    int tgt_i[DEPTH];
    int tgt_p[DEPTH];
    logic exp_acc = 1'b0;
    logic exp_v1, exp_v2;
    logic [15:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_int(input int c, input int t, input int r);
        if (t - c <= r && c - t <= r) return t;
        return (t > c) ? c + r : c - r;
    endfunction

    function automatic int step_ph(input int c, input int t, input int r);
        int d;
        d = t - c;
        if (d > 32767) d -= 65536;
        if (d < -32768) d += 65536;
        if (d == -32768) d = 32768;
        if (d <= r && d >= -r) return t;
        return (d > 0) ? ((c + r) & 65535) : ((c - r + 65536) & 65535);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ci_m[i] = 0;
            cp_m[i] = 0;
        end
        exp_q.delete();
        exp_acc = 1'b0;
    endtask

    // driver: burst of n samples; rates switch to ri2/rp2 from index chg_at; reset asserted at index rst_at
    task automatic send_burst(input int n, input int ri, input int rp,
                              input int chg_at, input int ri2, input int rp2, input int rst_at);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK); #1;
            DIN_VALID             = 1'b1;
            INTENSITY_IN          = (k < DEPTH) ? 8'(tgt_i[k]) : 8'($urandom_range(0, 255));
            PHASE_IN              = (k < DEPTH) ? 8'(tgt_p[k]) : 8'($urandom_range(0, 255));
            UPDATE_RATE_INTENSITY = (k >= chg_at) ? 16'(ri2) : 16'(ri);
            UPDATE_RATE_PHASE     = (k >= chg_at) ? 16'(rp2) : 16'(rp);
            if (k == rst_at) begin
                RST_N = 1'b0;
                model_reset();
                break;
            end
            exp_acc = (k < DEPTH);
            if (k < DEPTH) begin
                ci_m[k] = step_int(ci_m[k], tgt_i[k] * 256, ri);
                cp_m[k] = step_ph(cp_m[k], tgt_p[k] * 256, rp);
                exp_q.push_back({8'(ci_m[k] >> 8), 8'(cp_m[k] >> 8)});
            end
        end
        @(posedge CLK); #1;
        DIN_VALID = 1'b0;
        exp_acc   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic fill_targets(input int ti, input int tp);
        for (int i = 0; i < DEPTH; i++) begin
            tgt_i[i] = (ti < 0) ? int'($urandom_range(0, 255)) : ti;
            tgt_p[i] = (tp < 0) ? int'($urandom_range(0, 255)) : tp;
        end
    endtask

    // expected DOUT_VALID: accepted-input flag delayed two clocks
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_v1 <= 1'b0;
            exp_v2 <= 1'b0;
        end else begin
            exp_v1 <= exp_acc;
            exp_v2 <= exp_v1;
        end
    end

    // scoreboard
    always @(negedge CLK) begin
        if (!RST_N) begin
            check("rst_valid", 32'(DOUT_VALID), 32'd0);
            check("rst_out", {INTENSITY_OUT, PHASE_OUT}, 32'd0);
            last_out = '0;
        end else begin
            check("dout_valid", 32'(DOUT_VALID), 32'(exp_v2));
            if (DOUT_VALID) begin
                if (exp_q.size() == 0) begin
                    check("out_without_expect", 32'(DOUT_VALID), 32'd0);
                end else begin
                    last_out = exp_q.pop_front();
                    check("out_data", {INTENSITY_OUT, PHASE_OUT}, 32'(last_out));
                end
            end else begin
                check("hold", {INTENSITY_OUT, PHASE_OUT}, 32'(last_out));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;

        // ramp: intensity 1,2,3 at rate 0x0100
        fill_targets(255, 0);
        repeat (3) send_burst(DEPTH, 16'h0100, 16'h0100, DEPTH, 0, 0, -1);

        // full rate: outputs follow inputs
        fill_targets(-1, -1);
        send_burst(DEPTH, 16'hFFFF, 16'hFFFF, DEPTH, 0, 0, -1);

        // short burst, then random rates in both directions
        fill_targets(-1, -1);
        send_burst(30, $urandom_range(0, 65535), $urandom_range(0, 65535), DEPTH, 0, 0, -1);
        repeat (2) begin
            fill_targets(-1, -1);
            send_burst(DEPTH, $urandom_range(0, 2048), $urandom_range(0, 65535), DEPTH, 0, 0, -1);
        end

        // phase wrap: 250 -> 5 at 0x0200
        fill_targets(-1, 250);
        send_burst(DEPTH, 16'hFFFF, 16'hFFFF, DEPTH, 0, 0, -1);
        fill_targets(-1, 5);
        repeat (7) send_burst(DEPTH, 16'h0100, 16'h0200, DEPTH, 0, 0, -1);

        // mid-burst rate change at index 100 only applies next burst
        fill_targets(0, -1);
        send_burst(DEPTH, 16'h0100, 16'h0300, 100, 16'h0800, 16'h1000, -1);
        fill_targets(255, -1);
        send_burst(DEPTH, 16'h0800, 16'h1000, DEPTH, 0, 0, -1);

        // half turn from zero, then rate 0 holds
        do_reset();
        fill_targets(-1, 128);
        send_burst(DEPTH, 16'h0100, 16'h0100, DEPTH, 0, 0, -1);
        send_burst(DEPTH, 16'h0000, 16'h0000, DEPTH, 0, 0, -1);

        // reset mid-burst, then overlong burst from zero state
        fill_targets(-1, -1);
        send_burst(DEPTH, 16'h0400, 16'h0400, DEPTH, 0, 0, 50);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        fill_targets(-1, -1);
        send_burst(DEPTH + 5, 16'h0400, 16'h0400, DEPTH, 0, 0, -1);

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/silencer_fixed_rate.md
SILENCER_FIXED_RATE -- requirements
Module: silencer_fixed_rate

Interface
REQ-001 SHALL have parameter DEPTH, default 249, giving the number of transducer channels per burst.
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous reset, active-low.
REQ-004 SHALL have port DIN_VALID, input, 1 bit: the sample on INTENSITY_IN/PHASE_IN is valid; driven by the upstream stm stage.
REQ-005 SHALL have port INTENSITY_IN, input, 8 bits: target intensity for the current channel.
REQ-006 SHALL have port PHASE_IN, input, 8 bits: target phase for the current channel.
REQ-007 SHALL have port UPDATE_RATE_INTENSITY, input, 16 bits: maximum intensity step per burst, in 1/256 LSB.
REQ-008 SHALL have port UPDATE_RATE_PHASE, input, 16 bits: maximum phase step per burst, in 1/256 LSB.
REQ-009 SHALL have port INTENSITY_OUT, output, 8 bits: silenced intensity.
REQ-010 SHALL have port PHASE_OUT, output, 8 bits: silenced phase.
REQ-011 SHALL have port DOUT_VALID, output, 1 bit: INTENSITY_OUT/PHASE_OUT are valid.

Function
REQ-012 SHALL treat a burst as consecutive DIN_VALID=1 cycles; channel index = 0 on the first valid cycle after DIN_VALID=0 (or after reset), incrementing by 1 per valid cycle.
REQ-013 SHALL keep per-channel 16-bit state CI[i] (intensity) and CP[i] (phase), value = output<<8 | fraction.
REQ-014 SHALL latch both update rates on burst index 0 and use the latched values for the whole burst; mid-burst rate changes take effect at the next burst.
REQ-015 SHALL compute intensity as: T = INTENSITY_IN<<8; if |T-CI| <= rate then CI := T, else CI := CI ± rate toward T (unsigned, no wrap).
REQ-016 SHALL compute phase modulo 2^16: d = (T-CP) as a signed 16-bit value; if |d| <= rate then CP := T, else CP := CP + sign(d)*rate mod 2^16 (shortest path).
REQ-017 SHALL move a phase difference of exactly -32768 (half turn) in the positive direction.
REQ-018 SHALL hold state unchanged when the rate is 0.
REQ-019 SHALL output the upper 8 bits of the updated CI[i]/CP[i] for channel i, exactly 2 CLK cycles after that channel's input cycle.
REQ-020 SHALL drive DOUT_VALID as DIN_VALID delayed by 2 cycles, masked low for input indices >= DEPTH.
REQ-021 SHALL ignore samples at index >= DEPTH (no state change, no output) until DIN_VALID returns to 0.
REQ-022 SHALL update only the received channels on a burst shorter than DEPTH; the other channels retain their state.
REQ-023 SHALL hold INTENSITY_OUT/PHASE_OUT at their last values while DOUT_VALID=0.
REQ-024 SHALL be implemented with per-channel state in inferred RAM (read index i, write index i, 2-stage pipeline); back-to-back bursts separated by one idle cycle SHALL be handled without a hazard.

Reset
REQ-025 SHALL, while RST_N=0, clear all CI/CP to 0, the channel index to 0, the latched rates to 0, INTENSITY_OUT/PHASE_OUT to 0, DOUT_VALID to 0, and the pipeline valids to 0.
REQ-026 SHALL, on reset asserted mid-burst, discard in-flight samples; the first valid cycle after RST_N rises SHALL be index 0.

Verification
REQ-027 After reset, send 3 bursts of DEPTH samples with intensity 255, phase 0, rate_I=0x0100 -> every channel outputs intensity 1, 2, 3 and phase 0; DOUT_VALID high for exactly DEPTH cycles per burst, 2 cycles after the input.
REQ-028 Rates 0xFFFF, send random targets -> outputs equal the inputs on the first burst; latency 2 cycles.
REQ-029 Phase wrap: settle at 250 with rate 0xFFFF, then target 5 with rate 0x0200 -> successive bursts output 252, 254, 0, 2, 4, 5, 5.
REQ-030 Half turn: from phase 0, target 128, rate 0x0100 -> output 1; rate 0 -> output unchanged.
REQ-031 Change the rate at index 100 mid-burst -> channels 100..DEPTH-1 use the old rate; the next burst uses the new rate.
REQ-032 Assert RST_N=0 at index 50; send a burst of DEPTH+5 samples -> outputs for DEPTH samples from zero state, no output for the 5 extra samples.
